reg_timer_fmt: RTL
==================

Name: reg_timer_fmt

Overview:
- Next-generation time-of-day register block for the digital watch: seconds/minutes/hours counter driven by a parametrised one-second prescaler.
- Adds to the existing timer/set behaviour: runtime 12/24-hour display format, PM flag, packed-BCD or binary output encoding, seconds clear in set mode, and carry pulse outputs for chime/alarm logic.
- Sits between the clock divider/key debouncer and the display multiplexer.

Parameters:
- second_cnt, 50000000, clock cycles per second tick; legal range ≥2.
- BCD_OUT, 1, 1 = outputs are packed BCD (tens in [7:4], units in [3:0]); 0 = plain binary.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  1 = timer (running); 0 = set (time frozen, edits allowed).
- minute_set  in  1  level; in set mode, minute +1 per second tick.
- hour_set  in  1  level; in set mode, hour +1 per second tick.
- second_clear  in  1  level; in set mode, forces seconds to 0.
- hour_format  in  1  0 = 24-hour display; 1 = 12-hour display.
- second_data  out  8  seconds 0..59, encoded per BCD_OUT.
- minute_data  out  8  minutes 0..59, encoded per BCD_OUT.
- hour_data  out  8  hours: 0..23 (24h) or 1..12 (12h), encoded per BCD_OUT.
- pm_flag  out  1  1 when internal hour ≥12, in both formats.
- second_tick  out  1  one-cycle pulse on each prescaler terminal count.
- minute_carry  out  1  one-cycle pulse when seconds wrap 59→0 in timer mode.
- hour_carry  out  1  one-cycle pulse when minutes wrap 59→0 through a seconds carry.

Behaviour:
- Internal state:
  - Binary registers sec (6b), min (6b), hr (5b); hr is always 0..23.
  - Prescaler pcnt counts 0..second_cnt-1.
- Reset (reset=0, asynchronous):
  - pcnt, sec, min, hr cleared; all pulses 0.
  - Outputs: second_data=0, minute_data=0, pm_flag=0; hour_data=0 if hour_format=0, 12 (0x12 in BCD) if hour_format=1.
- Prescaler:
  - Increments every clock; at second_cnt-1 wraps to 0.
  - second_tick is high during the cycle pcnt==second_cnt-1, so it runs in both modes.
  - A 0→1 change of mode (registered edge detect) clears pcnt on the next edge, so the first running second is a full period.
- Timer mode (mode=1), on second_tick:
  - sec+1; at 59 wraps to 0 and increments min.
  - min at 59 wraps to 0 and increments hr.
  - hr at 23 wraps to 0.
  - set inputs and second_clear are ignored.
- Set mode (mode=0):
  - sec holds.
  - On second_tick: minute_set → min+1, wrap 59→0 with no hour carry; hour_set → hr+1, wrap 23→0.
  - Both set inputs high → both increment on the same tick.
  - second_clear=1 → sec=0 on the next edge, independent of tick, and wins over hold.
  - minute_carry and hour_carry stay 0.
- Carry pulses:
  - Registered; asserted the cycle after the edge on which the wrap occurred; width exactly one cycle.
  - At 23:59:59→00:00:00 both pulses assert in the same cycle.
- Display conversion is combinational from the registers, with zero-cycle latency to hour_format changes:
  - 12h mapping: hr 0→12, 1..12→same, 13..23→hr-12.
  - pm_flag = (hr≥12).
  - BCD: tens = v/10, units = v%10; upper bits of binary outputs are 0.
- Mode change mid-second: the pcnt value is retained except for the 0→1 clear; no partial tick is generated.
- Reset mid-operation: immediate clear regardless of mode; no carry pulse is produced by reset.

Test Plan (second_cnt=4, clock period 2 ns):
- Reset released, mode=1, 4×60×4 cycles → minute_data=0x04, second_data=0x00; minute_carry pulsed exactly 4 times, hour_carry never.
- Preload via set mode to 23:59:50, mode=1, run 10 ticks → 00:00:00; minute_carry and hour_carry high in the same single cycle; pm_flag 1→0.
- mode=0 at 00:04:xx, minute_set=1 for 60 ticks → minute returns to 4, hour unchanged, sec frozen. Then hour_set=1 for 24 ticks → hour unchanged (full wrap).
- Set mode with minute_set=hour_set=1 for 3 ticks from 00:00 → 03:03. Then second_clear pulse → second_data=0 next cycle.
- hour_format toggled with hr=0, 12, 13, 23 → hour_data 12/12/1/11 in 12h and 0/12/13/23 in 24h; pm_flag 0/1/1/1. BCD_OUT=0 instance shows 13 as 8'd13 and BCD_OUT=1 shows 8'h13.
- Assert reset at pcnt=2 mid-run → all outputs clear asynchronously. After release, first second_tick occurs exactly 4 cycles later; mode 0→1 transition also yields a full 4-cycle first second.

Source files
------------

// File: rtl/reg_timer_fmt_if.sv
// reg_timer_fmt_if: watch time-of-day register bus (controls in, display/pulses out)
// master: drives mode/set/clear/format, observes time and pulses
// slave:  the register block itself
interface reg_timer_fmt_if;
  logic       mode;
  logic       minute_set;
  logic       hour_set;
  logic       second_clear;
  logic       hour_format;
  logic [7:0] second_data;
  logic [7:0] minute_data;
  logic [7:0] hour_data;
  logic       pm_flag;
  logic       second_tick;
  logic       minute_carry;
  logic       hour_carry;
  modport master (
    output mode, minute_set, hour_set, second_clear, hour_format,
    input  second_data, minute_data, hour_data, pm_flag, second_tick, minute_carry, hour_carry
  );
  modport slave (
    input  mode, minute_set, hour_set, second_clear, hour_format,
    output second_data, minute_data, hour_data, pm_flag, second_tick, minute_carry, hour_carry
  );
endinterface

// File: rtl/reg_timer_fmt.sv
// reg_timer_fmt: time-of-day registers with prescaler, set mode, 12/24h and BCD/binary display
// clock, reset (async active-low)
// bus.mode 1=run 0=set; bus.minute_set/hour_set/second_clear edit in set mode; bus.hour_format 1=12h
// bus.second/minute/hour_data display values, pm_flag, second_tick, minute_carry, hour_carry pulses
module reg_timer_fmt #(
  parameter int second_cnt = 50000000,
  parameter bit BCD_OUT    = 1
) (
  input logic           clock,
  input logic           reset,
  reg_timer_fmt_if.slave bus
);
  localparam int PW = $clog2(second_cnt);
  logic [PW-1:0] pcnt;
  logic [5:0] sec, min;
  logic [4:0] hr, h12, hdisp;
  logic mode_q, tick, rise, adv, sec_wrap, min_wrap, mc_q, hc_q;
  function automatic logic [7:0] enc(input logic [5:0] v);
    return BCD_OUT ? {4'(v / 6'd10), 4'(v % 6'd10)} : {2'b00, v};
  endfunction
  assign tick     = pcnt == PW'(second_cnt - 1);
  // entering run mode restarts the second, so a tick on that same edge is swallowed
  assign rise     = bus.mode & ~mode_q;
  assign adv      = bus.mode & tick & mode_q;
  assign sec_wrap = sec == 6'd59;
  assign min_wrap = min == 6'd59;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt   <= '0;
      sec    <= '0;
      min    <= '0;
      hr     <= '0;
      mode_q <= 1'b1;
      mc_q   <= 1'b0;
      hc_q   <= 1'b0;
    end else begin
      pcnt   <= (tick | rise) ? '0 : pcnt + 1'b1;
      mode_q <= bus.mode;
      mc_q   <= adv & sec_wrap;
      hc_q   <= adv & sec_wrap & min_wrap;
      if (bus.mode) begin
        if (adv) begin
          sec <= sec_wrap ? '0 : sec + 6'd1;
          if (sec_wrap) begin
            min <= min_wrap ? '0 : min + 6'd1;
            if (min_wrap) hr <= (hr == 5'd23) ? '0 : hr + 5'd1;
          end
        end
      end else begin
        if (bus.second_clear) sec <= '0;
        if (tick & bus.minute_set) min <= min_wrap ? '0 : min + 6'd1;
        if (tick & bus.hour_set) hr <= (hr == 5'd23) ? '0 : hr + 5'd1;
      end
    end
  end
  always_comb begin
    h12   = (hr == 5'd0) ? 5'd12 : (hr > 5'd12) ? hr - 5'd12 : hr;
    hdisp = bus.hour_format ? h12 : hr;
  end
  assign bus.second_data  = enc(sec);
  assign bus.minute_data  = enc(min);
  assign bus.hour_data    = enc({1'b0, hdisp});
  assign bus.pm_flag      = hr >= 5'd12;
  assign bus.second_tick  = tick;
  assign bus.minute_carry = mc_q;
  assign bus.hour_carry   = hc_q;
endmodule
